// File: rtl/ebob_pkg.sv
// Shared types and defaults for the subtractive-Euclid GCD engine.
package ebob_pkg;

  localparam int EBOB_WIDTH = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ebob_step.sv
// One combinational Euclid step: reduce the larger operand, or flag completion.
module ebob_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] next_a,
  output logic [WIDTH-1:0] next_b,
  output logic             finished,
  output logic [WIDTH-1:0] result
);

  // A zero operand yields the other one, which also covers gcd(0,0)=0.
  assign finished = (a == '0) || (b == '0) || (a == b);
  assign result   = (a == '0) ? b : a;
  assign next_a   = (a > b) ? a - b : a;
  assign next_b   = (a < b) ? b - a : b;

endmodule

// File: rtl/ebob.sv
// Free-running GCD engine: latches operands, subtracts once per clock,
// holds the result until the operands change.
module ebob
  import ebob_pkg::*;
#(
  parameter int WIDTH = EBOB_WIDTH
) (
  input  logic             clk,
  input  logic             clkrst,
  input  logic [WIDTH-1:0] numb1,
  input  logic [WIDTH-1:0] numb2,
  output logic [WIDTH-1:0] ebobb,
  output logic             done
);

  state_t           state, state_d;
  logic [WIDTH-1:0] a, b, op1, op2;
  logic [WIDTH-1:0] a_d, b_d, op1_d, op2_d, ebobb_d;
  logic             done_d;

  logic [WIDTH-1:0] step_a, step_b, step_res;
  logic             step_fin;

  ebob_step #(.WIDTH(WIDTH)) u_step (
    .a        (a),
    .b        (b),
    .next_a   (step_a),
    .next_b   (step_b),
    .finished (step_fin),
    .result   (step_res)
  );

  always_comb begin
    state_d = state;
    a_d     = a;
    b_d     = b;
    op1_d   = op1;
    op2_d   = op2;
    ebobb_d = ebobb;
    done_d  = done;
    case (state)
      LOAD: begin
        a_d     = numb1;
        b_d     = numb2;
        op1_d   = numb1;
        op2_d   = numb2;
        done_d  = 1'b0;
        state_d = CALC;
      end
      CALC: begin
        if (step_fin) begin
          ebobb_d = step_res;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          a_d = step_a;
          b_d = step_b;
        end
      end
      DONE: begin
        // Operands are only compared here; changes mid-compute are ignored.
        if (numb1 != op1 || numb2 != op2) begin
          done_d  = 1'b0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge clkrst) begin
    if (!clkrst) begin
      state <= LOAD;
      a     <= '0;
      b     <= '0;
      op1   <= '0;
      op2   <= '0;
      ebobb <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      a     <= a_d;
      b     <= b_d;
      op1   <= op1_d;
      op2   <= op2_d;
      ebobb <= ebobb_d;
      done  <= done_d;
    end
  end

endmodule

// File: tb/tb_ebob.sv
// Scoreboard bench for ebob: stimulus pushes expected result and completion
// cycle, a negedge monitor checks done rises, result values and hold behaviour.
module tb_ebob;

  localparam int W = 4;

  logic         clk;
  logic         clkrst;
  logic [W-1:0] numb1, numb2;
  logic [W-1:0] ebobb;
  logic         done;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc;
  int           tests;
  int           fails;
  logic [W-1:0] last;
  logic         prev_done;
  int           cur1, cur2;

  ebob #(.WIDTH(W)) dut (
    .clk    (clk),
    .clkrst (clkrst),
    .numb1  (numb1),
    .numb2  (numb2),
    .ebobb  (ebobb),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Reference: Euclid by division. Subtraction count is the sum of the
  // quotients minus one, since the last step stops at equality.
  function automatic void ref_gcd(input int x, input int y, output int g, output int k);
    int p, q, r;
    if (x == 0 || y == 0) begin
      g = x + y;
      k = 0;
    end else begin
      p = x; q = y; k = 0;
      while (q != 0) begin
        k += p / q;
        r = p % q;
        p = q;
        q = r;
      end
      g = p;
      k = k - 1;
    end
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Change operands while the engine sits in DONE; recompute follows.
  task automatic apply(input int x, input int y);
    int g, k;
    exp_t e;
    @(negedge clk);
    numb1 = x[W-1:0];
    numb2 = y[W-1:0];
    cur1 = x; cur2 = y;
    ref_gcd(x, y, g, k);
    e.res = g[W-1:0];
    e.cyc = cyc + k + 3;
    sb.push_back(e);
    @(negedge clk);
    check("done drop after change", int'(done), 0);
    repeat (k + 4) @(negedge clk);
  endtask

  // Monitor: compares on each done rise, and checks ebobb holds otherwise.
  initial begin
    exp_t e;
    last = '0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          check("unexpected done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("result", int'(ebobb), int'(e.res));
          check("latency cycle", cyc, e.cyc);
          last = e.res;
        end
      end else begin
        check("ebobb hold", int'(ebobb), int'(last));
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
          e = sb.pop_front();
          check("done timeout", cyc, e.cyc);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    int x, y, g, k;
    exp_t e;
    tests = 0;
    fails = 0;
    clkrst = 1'b0;
    numb1 = 4'd15;
    numb2 = 4'd10;
    cur1 = 15; cur2 = 10;
    #100;
    check("reset ebobb", int'(ebobb), 0);
    check("reset done", int'(done), 0);
    @(negedge clk);
    clkrst = 1'b1;
    ref_gcd(15, 10, g, k);
    e.res = g[W-1:0];
    e.cyc = cyc + 1 + k + 1;
    sb.push_back(e);
    repeat (k + 5) @(negedge clk);

    apply(12, 8);
    apply(7, 13);
    apply(15, 15);
    apply(9, 3);
    apply(0, 9);
    apply(6, 0);
    apply(0, 0);
    apply(15, 1);
    apply(15, 10);
    apply(8, 12);

    for (int i = 0; i < 30; i++) begin
      do begin
        x = $urandom_range(0, 15);
        y = $urandom_range(0, 15);
      end while (x == cur1 && y == cur2);
      apply(x, y);
    end

    // Abort a long computation with an asynchronous reset between edges.
    apply(2, 2);
    @(negedge clk);
    numb1 = 4'd15;
    numb2 = 4'd1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    clkrst = 1'b0;
    sb.delete();
    last = '0;
    #1;
    check("async reset ebobb", int'(ebobb), 0);
    check("async reset done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    clkrst = 1'b1;
    ref_gcd(15, 1, g, k);
    e.res = g[W-1:0];
    e.cyc = cyc + 1 + k + 1;
    sb.push_back(e);
    repeat (k + 6) @(negedge clk);

    check("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: cycle %0d, expected finish earlier", cyc);
    $fatal(1);
  end

endmodule
